heard_collector: RTL and testbench

Downstream consumer of the delayed-echo stage's `indication$heard` interface. Buffers each heard value in a small circular FIFO, tags it with an 8-bit arrival sequence number, and forwards it on an `out$deliver` ENA/RDY interface toward the host indication path. Back-pressure on the upstream stage comes only from the FIFO's full condition.

---
 rtl/heard_collector_pkg.sv | 12 +
 rtl/heard_collector_if.sv | 23 ++
 rtl/heard_fifo_mem.sv | 31 +++
 rtl/heard_collector.sv | 89 ++++++++
 tb/tb_heard_collector.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/heard_collector_pkg.sv
// Shared types and constants for the heard_collector slice.
package heard_collector_pkg;

  localparam int SEQ_W         = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [31:0]      v;
  } heard_entry_t;

endpackage

// File: rtl/heard_collector_if.sv
// Handshake bundle: upstream indication heard and downstream out deliver ENA/RDY pairs.
interface heard_collector_if;
  import heard_collector_pkg::*;

  logic              indication_heard_ena;
  logic [31:0]       indication_heard_v;
  logic              indication_heard_rdy;
  logic              out_deliver_ena;
  logic [31:0]       out_deliver_v;
  logic [SEQ_W-1:0]  out_deliver_seq;
  logic              out_deliver_rdy;

  // The collector is the slave; the upstream stage and host side together form the master.
  modport slave (
    input  indication_heard_ena, indication_heard_v, out_deliver_rdy,
    output indication_heard_rdy, out_deliver_ena, out_deliver_v, out_deliver_seq
  );

  modport master (
    output indication_heard_ena, indication_heard_v, out_deliver_rdy,
    input  indication_heard_rdy, out_deliver_ena, out_deliver_v, out_deliver_seq
  );
endinterface

// File: rtl/heard_fifo_mem.sv
// DEPTH-entry register array: one synchronous write port, one asynchronous read port.
module heard_fifo_mem
  import heard_collector_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  heard_entry_t     wdata,
  input  logic [PTR_W-1:0] raddr,
  output heard_entry_t     rdata
);

  heard_entry_t mem [DEPTH];

  // NOTE: the array is small enough to be flops, so it is cleared on reset; stale-head
  // reads after reset then return zeros rather than X.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/heard_collector.sv
// Circular FIFO collecting heard values with an 8-bit arrival tag.
// Optional running sum of delivered values: define HEARD_COLLECTOR_SUM_EN.
module heard_collector
  import heard_collector_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  heard_collector_if.slave bus,
`ifdef HEARD_COLLECTOR_SUM_EN
  input  logic             sum_clear_ena,
  output logic [31:0]      sum_v,
`endif
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wp, rp;
  logic [PTR_W:0]   cnt;
  logic [SEQ_W-1:0] seq_ctr;
  logic             full, empty, enq, deq;
  heard_entry_t     wr_entry, head;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign enq   = bus.indication_heard_ena & ~full;
  assign deq   = ~empty & bus.out_deliver_rdy;

  assign wr_entry = '{seq: seq_ctr, v: bus.indication_heard_v};

  heard_fifo_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .CLK   (CLK),
    .nRST  (nRST),
    .we    (enq),
    .waddr (wp),
    .wdata (wr_entry),
    .raddr (rp),
    .rdata (head)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      seq_ctr <= '0;
    end else begin
      if (enq) begin
        wp      <= wp + 1'b1;
        seq_ctr <= seq_ctr + 1'b1;
      end
      if (deq) rp <= rp + 1'b1;
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Handshake outputs come only from registered state, so no input-to-output path exists.
  assign bus.indication_heard_rdy = ~full;
  assign bus.out_deliver_ena      = ~empty;
  assign bus.out_deliver_v        = head.v;
  assign bus.out_deliver_seq      = head.seq;
  assign count                    = cnt;

`ifdef HEARD_COLLECTOR_SUM_EN
  logic [31:0] sum;

  // A clear that coincides with a delivery keeps just the delivered value.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sum <= '0;
    end else if (sum_clear_ena) begin
      sum <= deq ? head.v : 32'h0;
    end else if (deq) begin
      sum <= sum + head.v;
    end
  end

  assign sum_v = sum;
`endif

endmodule

// File: tb/tb_heard_collector.sv
// Directed self-checking bench for heard_collector (DEPTH=4); sum checks when HEARD_COLLECTOR_SUM_EN is set.
module tb_heard_collector;
  import heard_collector_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [2:0]  count;
`ifdef HEARD_COLLECTOR_SUM_EN
  logic        sum_clear;
  logic [31:0] sum_v;
`endif

  int passed = 0;
  int total  = 0;

  heard_collector_if bus ();

  heard_collector #(.DEPTH(4)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .bus           (bus),
`ifdef HEARD_COLLECTOR_SUM_EN
    .sum_clear_ena (sum_clear),
    .sum_v         (sum_v),
`endif
    .count         (count)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    bus.indication_heard_ena = 1'b0;
    bus.indication_heard_v   = '0;
    bus.out_deliver_rdy      = 1'b0;
`ifdef HEARD_COLLECTOR_SUM_EN
    sum_clear = 1'b0;
`endif
    step();
    step();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    total++;
    if (bus.indication_heard_rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", bus.indication_heard_rdy);
    else passed++;
    total++;
    if (bus.out_deliver_ena !== 1'b0) $display("FAIL reset_ena: got %b want 0", bus.out_deliver_ena);
    else passed++;
    total++;
    if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count);
    else passed++;
  endtask

  task automatic test_in_order();
    logic [31:0] vals [3];
    vals = '{32'h11, 32'h22, 32'h33};
    do_reset();
    bus.out_deliver_rdy = 1'b1;
    bus.indication_heard_ena = 1'b1;
    bus.indication_heard_v   = vals[0];
    #1;
    total++;
    if (bus.out_deliver_ena !== 1'b0) $display("FAIL no_bypass: got %b want 0", bus.out_deliver_ena);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      bus.indication_heard_v = vals[i];
      step();
      total++;
      if (bus.out_deliver_ena !== 1'b1) $display("FAIL order_ena[%0d]: got %b want 1", i, bus.out_deliver_ena);
      else passed++;
      total++;
      if (bus.out_deliver_v !== vals[i]) $display("FAIL order_v[%0d]: got %h want %h", i, bus.out_deliver_v, vals[i]);
      else passed++;
      total++;
      if (bus.out_deliver_seq !== 8'(i)) $display("FAIL order_seq[%0d]: got %0d want %0d", i, bus.out_deliver_seq, i);
      else passed++;
      total++;
      if (count !== 3'd1) $display("FAIL order_count[%0d]: got %0d want 1", i, count);
      else passed++;
    end
    bus.indication_heard_ena = 1'b0;
    step();
    total++;
    if (bus.out_deliver_ena !== 1'b0) $display("FAIL order_drained_ena: got %b want 0", bus.out_deliver_ena);
    else passed++;
    total++;
    if (count !== 3'd0) $display("FAIL order_drained_count: got %0d want 0", count);
    else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_deliver_rdy = 1'b0;
    bus.indication_heard_ena = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.indication_heard_v = 32'hA0 + 32'(i);
      #1;
      total++;
      if (bus.indication_heard_rdy !== 1'b1) $display("FAIL bp_rdy_before[%0d]: got %b want 1", i, bus.indication_heard_rdy);
      else passed++;
      step();
    end
    total++;
    if (count !== 3'd4) $display("FAIL bp_full_count: got %0d want 4", count);
    else passed++;
    total++;
    if (bus.indication_heard_rdy !== 1'b0) $display("FAIL bp_full_rdy: got %b want 0", bus.indication_heard_rdy);
    else passed++;
    // Fifth value offered while full must be held off.
    bus.indication_heard_v = 32'hA4;
    step();
    total++;
    if (count !== 3'd4) $display("FAIL bp_held_count: got %0d want 4", count);
    else passed++;
    total++;
    if (bus.out_deliver_v !== 32'hA0 || bus.out_deliver_seq !== 8'd0)
      $display("FAIL bp_head: got %h/%0d want a0/0", bus.out_deliver_v, bus.out_deliver_seq);
    else passed++;
    // Full with simultaneous offer and dequeue: only the dequeue happens.
    bus.out_deliver_rdy = 1'b1;
    step();
    bus.out_deliver_rdy = 1'b0;
    total++;
    if (count !== 3'd3) $display("FAIL bp_release_count: got %0d want 3", count);
    else passed++;
    total++;
    if (bus.indication_heard_rdy !== 1'b1) $display("FAIL bp_release_rdy: got %b want 1", bus.indication_heard_rdy);
    else passed++;
    step();
    bus.indication_heard_ena = 1'b0;
    total++;
    if (count !== 3'd4) $display("FAIL bp_fifth_count: got %0d want 4", count);
    else passed++;
    bus.out_deliver_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (bus.out_deliver_v !== 32'hA0 + 32'(i) || bus.out_deliver_seq !== 8'(i))
        $display("FAIL bp_drain[%0d]: got %h/%0d want %h/%0d", i, bus.out_deliver_v, bus.out_deliver_seq,
                 32'hA0 + 32'(i), i);
      else passed++;
      step();
    end
    total++;
    if (count !== 3'd0 || bus.out_deliver_ena !== 1'b0)
      $display("FAIL bp_empty: got count %0d ena %b want 0/0", count, bus.out_deliver_ena);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.out_deliver_rdy = 1'b1;
    bus.indication_heard_ena = 1'b1;
    for (int i = 0; i < 258; i++) begin
      bus.indication_heard_v = 32'h1000 + 32'(i);
      step();
      total++;
      if (bus.out_deliver_ena !== 1'b1 || bus.out_deliver_v !== 32'h1000 + 32'(i) ||
          bus.out_deliver_seq !== 8'(i % 256) || count !== 3'd1)
        $display("FAIL b2b[%0d]: got ena %b v %h seq %0d cnt %0d want 1 %h %0d 1", i, bus.out_deliver_ena,
                 bus.out_deliver_v, bus.out_deliver_seq, count, 32'h1000 + 32'(i), i % 256);
      else passed++;
    end
    bus.out_deliver_rdy = 1'b0;
    bus.indication_heard_v = 32'hBEEF;
    step();
    bus.indication_heard_ena = 1'b0;
    total++;
    if (count !== 3'd2) $display("FAIL midrst_pre_count: got %0d want 2", count);
    else passed++;
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    total++;
    if (count !== 3'd0 || bus.out_deliver_ena !== 1'b0 || bus.indication_heard_rdy !== 1'b1)
      $display("FAIL midrst_state: got cnt %0d ena %b rdy %b want 0 0 1", count, bus.out_deliver_ena,
               bus.indication_heard_rdy);
    else passed++;
    bus.indication_heard_ena = 1'b1;
    bus.indication_heard_v   = 32'h55;
    step();
    bus.indication_heard_ena = 1'b0;
    total++;
    if (bus.out_deliver_seq !== 8'd0 || bus.out_deliver_v !== 32'h55)
      $display("FAIL midrst_seq: got %h/%0d want 55/0", bus.out_deliver_v, bus.out_deliver_seq);
    else passed++;
  endtask

`ifdef HEARD_COLLECTOR_SUM_EN
  task automatic test_sum();
    do_reset();
    step();
    total++;
    if (sum_v !== 32'h0) $display("FAIL sum_reset: got %h want 0", sum_v);
    else passed++;
    bus.out_deliver_rdy = 1'b1;
    bus.indication_heard_ena = 1'b1;
    bus.indication_heard_v   = 32'hFFFF_FFFF;
    step();
    bus.indication_heard_v   = 32'h2;
    step();
    bus.indication_heard_ena = 1'b0;
    step();
    total++;
    if (sum_v !== 32'h1) $display("FAIL sum_wrap: got %h want 1", sum_v);
    else passed++;
    bus.indication_heard_ena = 1'b1;
    bus.indication_heard_v   = 32'h7;
    step();
    bus.indication_heard_ena = 1'b0;
    sum_clear = 1'b1;
    step();
    sum_clear = 1'b0;
    total++;
    if (sum_v !== 32'h7) $display("FAIL sum_clear_deliver: got %h want 7", sum_v);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_in_order();
    test_backpressure();
    test_back_to_back();
`ifdef HEARD_COLLECTOR_SUM_EN
    test_sum();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
